alu_op_sequencer: RTL and testbench

Synthesizable initiator for the team's 4-bit combinational ALU. On a start pulse it latches two operands, then drives the ALU through all eight select codes, waiting a programmable settle time before each capture. It stores each `{carry_out, alu_out}` result in an 8-entry result buffer, which a host reads by select code. It sits between a host/control interface and the ALU's `a`, `b`, `alu_sel`, `alu_out` and `carry_out` ports.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_buf.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operation sequencer.
//   ALU_DATA_W  - default operand/result width of the team ALU
//   ALU_SEL_W   - default select width of the team ALU
//   ALU_NUM_OPS - number of ALU select codes
//   seq_state_t - sequencer FSM state encoding
package alu_pkg;

    localparam int ALU_DATA_W  = 4;
    localparam int ALU_SEL_W   = 3;
    localparam int ALU_NUM_OPS = 2 ** ALU_SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_result_buf.sv
// alu_result_buf: result register file, one entry per ALU select code.
//   clk, rst_n   - clock, asynchronous active-low reset (clears data and valid)
//   clr_valid_i  - clears every valid bit (data is kept)
//   we_i         - write strobe: mem[waddr_i] <= wdata_i and sets its valid bit
//   waddr_i      - write index
//   wdata_i      - {carry, result} to store
//   rd_addr_i    - read index
//   rd_data_o    - combinational read data at rd_addr_i
//   rd_valid_o   - valid bit at rd_addr_i
module alu_result_buf
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_valid_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  waddr_i,
    input  logic [DATA_W:0]   wdata_i,
    input  logic [SEL_W-1:0]  rd_addr_i,
    output logic [DATA_W:0]   rd_data_o,
    output logic              rd_valid_o
);

    localparam int DEPTH = 2 ** SEL_W;

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            // Clear and write never coincide in the sequencer, but a write
            // is ordered after the clear so it would still win.
            if (clr_valid_i) begin
                valid_q <= '0;
            end
            if (we_i) begin
                mem_q[waddr_i]   <= wdata_i;
                valid_q[waddr_i] <= 1'b1;
            end
        end
    end

    assign rd_data_o  = mem_q[rd_addr_i];
    assign rd_valid_o = valid_q[rd_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sweeps the team ALU through every select code for one
// operand pair and stores each {carry_out, alu_out} result.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, abort      - begin a sweep (IDLE only) / cancel a sweep (wins)
//   op_a, op_b        - operands, latched when a start is accepted
//   alu_a, alu_b      - operands driven to the ALU
//   alu_sel           - select code driven to the ALU
//   alu_out, carry_out- ALU result inputs
//   busy              - high while sweeping (WAIT/CAP)
//   done              - one-cycle pulse when the sweep completes
//   rd_addr           - result read index (select code)
//   rd_data, rd_valid - {carry, result} and its valid bit at rd_addr
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int SEL_W  = ALU_SEL_W,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              carry_out,
    output logic              busy,
    output logic              done,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [DATA_W:0]   rd_data,
    output logic              rd_valid
);

    localparam int                NUM_OPS    = 2 ** SEL_W;
    localparam int                CNT_W      = 4;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL   = SEL_W'(NUM_OPS - 1);

    seq_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              done_q;

    logic buf_we;
    logic buf_clr;

    // Capture happens on the edge that ends the CAP cycle unless aborted.
    assign buf_we  = (state_q == CAP) && !abort;
    assign buf_clr = (state_q == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sel_q   <= '0;
                        cnt_q   <= CNT_RELOAD;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= CAP;
                    end
                end
                CAP: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sel_q == LAST_SEL) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        sel_q   <= sel_q + 1'b1;
                        cnt_q   <= CNT_RELOAD;
                        state_q <= WAIT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    alu_result_buf #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_valid_i (buf_clr),
        .we_i        (buf_we),
        .waddr_i     (sel_q),
        .wdata_i     ({carry_out, alu_out}),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid)
    );

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a SETTLE=1
// instance (dut) and a SETTLE=3 instance (dut3), each wired to the model ALU
// alu_out = alu_a ^ alu_sel, carry_out = alu_sel[0].
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;

    logic       start, abort;
    logic [3:0] op_a, op_b, alu_a, alu_b, alu_out;
    logic [2:0] alu_sel, rd_addr;
    logic       carry_out, busy, done, rd_valid;
    logic [4:0] rd_data;

    logic       start3, abort3;
    logic [3:0] op_a3, op_b3, alu_a3, alu_b3, alu_out3;
    logic [2:0] alu_sel3, rd_addr3;
    logic       carry_out3, busy3, done3, rd_valid3;
    logic [4:0] rd_data3;

    int tests;
    int fails;

    alu_op_sequencer #(.DATA_W(4), .SEL_W(3), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .carry_out(carry_out),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    alu_op_sequencer #(.DATA_W(4), .SEL_W(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .op_a(op_a3), .op_b(op_b3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_sel(alu_sel3), .alu_out(alu_out3), .carry_out(carry_out3),
        .busy(busy3), .done(done3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .rd_valid(rd_valid3)
    );

    assign alu_out    = alu_a ^ {1'b0, alu_sel};
    assign carry_out  = alu_sel[0];
    assign alu_out3   = alu_a3 ^ {1'b0, alu_sel3};
    assign carry_out3 = alu_sel3[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [3:0] a, input logic [2:0] s);
        return {s[0], a ^ {1'b0, s}};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({alu_a, alu_b, alu_sel, busy, done} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got a=%h b=%h sel=%0d busy=%b done=%b, want all 0",
                     alu_a, alu_b, alu_sel, busy, done);
        end
        tests++;
        if ({alu_a3, alu_b3, alu_sel3, busy3, done3} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs3: got a=%h b=%h sel=%0d busy=%b done=%b, want all 0",
                     alu_a3, alu_b3, alu_sel3, busy3, done3);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            tests++;
            if (rd_valid !== 1'b0 || rd_data !== 5'h00) begin
                fails++;
                $display("FAIL reset_buf[%0d]: got valid=%b data=%h, want 0/00", i, rd_valid, rd_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] exp;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);              // edge k
        #1 start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);          // cycle k+c
            tests++;
            if (busy !== (c < 16)) begin
                fails++;
                $display("FAIL sweep_busy c=%0d: got %b, want %b", c, busy, (c < 16));
            end
            tests++;
            if (done !== (c == 16)) begin
                fails++;
                $display("FAIL sweep_done c=%0d: got %b, want %b", c, done, (c == 16));
            end
        end
        tests++;
        if (alu_a !== a || alu_b !== b || alu_sel !== 3'd7) begin
            fails++;
            $display("FAIL sweep_hold: got a=%h b=%h sel=%0d, want a=%h b=%h sel=7",
                     alu_a, alu_b, alu_sel, a, b);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            exp = model(a, 3'(i));
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                fails++;
                $display("FAIL sweep_buf[%0d]: got valid=%b data=%h, want 1/%h", i, rd_valid, rd_data, exp);
            end
        end
    endtask

    task automatic test_settle3();
        @(negedge clk);
        op_a3 = 4'hA; op_b3 = 4'h2; start3 = 1'b1; rd_addr3 = 3'd0;
        @(posedge clk);              // edge k
        #1 start3 = 1'b0;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (c < 32) begin
                tests++;
                if (alu_sel3 !== 3'(c / 4)) begin
                    fails++;
                    $display("FAIL s3_sel c=%0d: got %0d, want %0d", c, alu_sel3, c / 4);
                end
            end
            if (c == 3 || c == 4) begin
                tests++;
                if (rd_valid3 !== (c == 4)) begin
                    fails++;
                    $display("FAIL s3_cap0 c=%0d: got valid=%b, want %b", c, rd_valid3, (c == 4));
                end
            end
            tests++;
            if (done3 !== (c == 32)) begin
                fails++;
                $display("FAIL s3_done c=%0d: got %b, want %b", c, done3, (c == 32));
            end
        end
        rd_addr3 = 3'd7;
        #1;
        tests++;
        if (rd_valid3 !== 1'b1 || rd_data3 !== 5'h1D) begin
            fails++;
            $display("FAIL s3_buf7: got valid=%b data=%h, want 1/1d", rd_valid3, rd_data3);
        end
    endtask

    task automatic test_abort(input logic [3:0] prev_a);
        logic [4:0] exp;
        @(negedge clk);
        op_a = 4'h9; op_b = 4'h1; start = 1'b1;
        @(posedge clk);              // edge k
        #1 start = 1'b0;
        repeat (6) @(posedge clk);   // edge k+6: op 2 captured
        #1 abort = 1'b1;
        @(posedge clk);              // edge k+7
        #1 abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL abort_idle c=%0d: got busy=%b done=%b, want 0/0", c, busy, done);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            exp = (i < 3) ? model(4'h9, 3'(i)) : model(prev_a, 3'(i));
            tests++;
            if (rd_valid !== (i < 3) || rd_data !== exp) begin
                fails++;
                $display("FAIL abort_buf[%0d]: got valid=%b data=%h, want %b/%h",
                         i, rd_valid, rd_data, (i < 3), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op_a = 4'h7; op_b = 4'h4; start = 1'b1;
        @(posedge clk);              // edge k
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tests++;
            if (busy !== ((c % 18) < 16) || done !== ((c % 18) == 16)) begin
                fails++;
                $display("FAIL b2b c=%0d: got busy=%b done=%b, want %b/%b",
                         c, busy, done, ((c % 18) < 16), ((c % 18) == 16));
            end
        end
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stop: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_a = 4'h6; op_b = 4'h6; start = 1'b1;
        @(posedge clk);              // edge k
        #1 start = 1'b0;
        repeat (10) @(posedge clk);  // edge k+10: now waiting on op 5
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({alu_a, alu_b, alu_sel, busy, done} !== 13'd0) begin
            fails++;
            $display("FAIL rstmid_out: got a=%h b=%h sel=%0d busy=%b done=%b, want all 0",
                     alu_a, alu_b, alu_sel, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            tests++;
            if (rd_valid !== 1'b0 || rd_data !== 5'h00) begin
                fails++;
                $display("FAIL rstmid_buf[%0d]: got valid=%b data=%h, want 0/00", i, rd_valid, rd_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_after c=%0d: got busy=%b done=%b, want 0/0", c, busy, done);
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; op_a = '0; op_b = '0; rd_addr = '0;
        start3 = 1'b0; abort3 = 1'b0; op_a3 = '0; op_b3 = '0; rd_addr3 = '0;
        test_reset();
        test_full_sweep(4'h5, 4'h3);
        test_settle3();
        test_abort(4'h5);
        test_full_sweep(4'hC, 4'h0);
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
